// File: rtl/ps2_receptor.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard lines,
// deserializes one 11-bit frame (start, 8 data LSB-first, odd parity, stop)
// and reports the scan code or the kind of error with one-cycle strobes.
module ps2_receptor #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_en,
    output logic [7:0] codigo,
    output logic       rx_done,
    output logic       err_paridad,
    output logic       err_trama,
    output logic       ocupado
);

    localparam int unsigned FLT_W = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATOS   = 2'd1,
        ST_PARIDAD = 2'd2,
        ST_PARADA  = 2'd3
    } state_t;

    logic             clk_s1_q, clk_s2_q;
    logic             dat_s1_q, dat_s2_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             filt_q, filt_prev_q;
    logic             fe_c;

    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       sr_q;
    logic             par_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [7:0]       codigo_q;
    logic             rx_done_q, err_par_q, err_tra_q, ocupado_q;

    // Two-flop synchronizers for both keyboard lines, preset to the idle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: follow the synchronized clock only after FILTER_LEN equal samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flt_cnt_q   <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_s2_q == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_cnt_q <= '0;
                filt_q    <= clk_s2_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + FLT_W'(1);
            end
        end
    end

    assign fe_c = filt_prev_q & ~filt_q;

    // Frame FSM with timeout supervision; strobes default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            codigo_q  <= '0;
            rx_done_q <= 1'b0;
            err_par_q <= 1'b0;
            err_tra_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            err_par_q <= 1'b0;
            err_tra_q <= 1'b0;

            if (fe_c || state_q == ST_IDLE) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            if (state_q != ST_IDLE && !fe_c && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                // Keyboard clock stalled mid-frame: abandon it
                state_q   <= ST_IDLE;
                ocupado_q <= 1'b0;
                err_tra_q <= 1'b1;
            end else if (fe_c) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!dat_s2_q && rx_en) begin
                            state_q   <= ST_DATOS;
                            ocupado_q <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATOS: begin
                        sr_q      <= {dat_s2_q, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARIDAD;
                        end
                    end
                    ST_PARIDAD: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_PARADA;
                    end
                    ST_PARADA: begin
                        // A bad stop bit outranks a parity failure
                        if (!dat_s2_q) begin
                            err_tra_q <= 1'b1;
                        end else if (^{sr_q, par_q}) begin
                            codigo_q  <= sr_q;
                            rx_done_q <= 1'b1;
                        end else begin
                            err_par_q <= 1'b1;
                        end
                        state_q   <= ST_IDLE;
                        ocupado_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        ocupado_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign codigo      = codigo_q;
    assign rx_done     = rx_done_q;
    assign err_paridad = err_par_q;
    assign err_trama   = err_tra_q;
    assign ocupado     = ocupado_q;

endmodule

// File: doc/ps2_receptor.md
PS2_RECEPTOR -- requirements
Module: ps2_receptor

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical ps2_clk samples required before the filtered clock changes level.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles allowed between falling edges inside a frame (2 ms at the 50 MHz nominal clk).
REQ-003 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ps2_clk  in  1  keyboard clock line, asynchronous to clk, idles high.
REQ-006 ps2_data  in  1  keyboard data line, asynchronous to clk, idles high.
REQ-007 rx_en  in  1  when high, a new frame may start.
REQ-008 codigo  out  8  last correctly received scan code, held between frames; feeds the downstream 8-bit code register.
REQ-009 rx_done  out  1  one-cycle strobe marking a valid new codigo; drives the downstream register enable.
REQ-010 err_paridad  out  1  one-cycle strobe on a parity failure.
REQ-011 err_trama  out  1  one-cycle strobe on a bad stop bit or a timeout.
REQ-012 ocupado  out  1  high while a frame is in progress (state not IDLE).

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer preset to 1.
REQ-014 The glitch filter SHALL change its output only after FILTER_LEN consecutive equal synchronized ps2_clk samples.
REQ-015 A falling-edge strobe (fe) SHALL be one clk cycle wide, asserted when the filtered clock goes 1->0.
REQ-016 The FSM SHALL have the states IDLE, DATOS, PARIDAD and PARADA.
REQ-017 IDLE: on fe with synchronized data=0 and rx_en=1, go to DATOS and clear the bit counter; on fe with data=1 or rx_en=0, stay in IDLE.
REQ-018 DATOS: on each fe, shift data in LSB-first (sr <= {data, sr[7:1]}) and increment the 3-bit counter; after the 8th bit, go to PARIDAD.
REQ-019 PARIDAD: on fe, capture the parity bit and go to PARADA; the frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
REQ-020 PARADA, on fe, with stop=1 and good parity: codigo <= sr and rx_done=1 in the next clk cycle, then go to IDLE.
REQ-021 PARADA, on fe, with stop=1 and bad parity: err_paridad=1 in the next cycle, codigo unchanged, no rx_done, then go to IDLE.
REQ-022 PARADA, on fe, with stop=0: err_trama=1 in the next cycle, codigo unchanged, no rx_done, no err_paridad (framing error takes priority), then go to IDLE.
REQ-023 Timeout counter: cleared on every fe and in IDLE, incremented each cycle otherwise; reaching TIMEOUT_CYC-1 outside IDLE SHALL return the FSM to IDLE and pulse err_trama once.
REQ-024 rx_en SHALL gate only the start of a frame; deasserting it mid-frame SHALL NOT abort the frame.
REQ-025 At most one of rx_done, err_paridad and err_trama SHALL be high in any cycle; each strobe SHALL last exactly one cycle.
REQ-026 Back-to-back frames SHALL be accepted with no dead time beyond the stop-bit fe.

Reset
REQ-027 While reset is high: state=IDLE, codigo=8'h00, all strobes=0, ocupado=0, synchronizers and filter output=1, counters=0, sr=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no strobe and leave codigo=0.

Verification
REQ-029 Frame 0x1C, parity 0, stop 1 -> exactly one rx_done pulse; codigo=0x1C.
REQ-030 Frame 0xF0 sent with parity 0 -> one err_paridad pulse; codigo stays 0x1C; no rx_done.
REQ-031 Frame 0x5A, parity 1, stop 0 -> one err_trama pulse; no rx_done; codigo unchanged.
REQ-032 Clock stops after 4 data bits -> err_trama pulse TIMEOUT_CYC cycles after the last fe and ocupado falls; a following frame 0x29 (parity 0) -> codigo=0x29.
REQ-033 A 6-cycle low glitch on ps2_clk in IDLE -> no fe and ocupado stays 0; frames 0xF0 then 0x1C back-to-back -> two rx_done pulses in order.
REQ-034 Reset pulse during DATOS -> ocupado=0, codigo=0x00, no strobes; the next valid frame is received correctly.
